// File: rtl/banco_registradores_param.sv
// ---------------------------------------------------------------------------
// banco_registradores_param
//
// Parametrised register bank: two registered read ports, one write port with
// same-cycle write-to-read bypass, optional hardwired-zero register 0 and a
// multi-cycle clear sweep that zeroes one register per clock.
//
// Parameters:
//   LARGURA  - data width of every register and data port
//   NUM_REGS - number of registers (2 .. 2**END_W)
//   END_W    - address width
//   R0_ZERO  - 1: register 0 reads as zero and ignores writes
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset_n   asynchronous active-low reset
//   sinal     write enable
//   entrada1  read address, port 1
//   entrada2  read address, port 2
//   entrada3  write address
//   dado      write data
//   le1/le2   read enables for ports 1 and 2
//   limpar    start clear sweep
//   saida1/2  registered read data
//   valido1/2 read data updated by the previous edge
//   ocupado   clear sweep in progress (reads and writes are ignored)
// ---------------------------------------------------------------------------
module banco_registradores_param #(
    parameter int LARGURA  = 16,
    parameter int NUM_REGS = 16,
    parameter int END_W    = 4,
    parameter int R0_ZERO  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sinal,
    input  logic [END_W-1:0]   entrada1,
    input  logic [END_W-1:0]   entrada2,
    input  logic [END_W-1:0]   entrada3,
    input  logic [LARGURA-1:0] dado,
    input  logic               le1,
    input  logic               le2,
    input  logic               limpar,
    output logic [LARGURA-1:0] saida1,
    output logic [LARGURA-1:0] saida2,
    output logic               valido1,
    output logic               valido2,
    output logic               ocupado
);

    // The read mux spans the full address space; unmapped addresses read 0.
    localparam int PROF = 2**END_W;
    // Counter is one bit wider than the address so NUM_REGS = 2**END_W is
    // representable without wrapping.
    localparam logic [END_W:0] ULTIMO = (END_W+1)'(NUM_REGS - 1);

    typedef enum logic {OCIOSO, LIMPANDO} estado_t;

    estado_t            estado;
    logic [END_W:0]     contador;
    logic [LARGURA-1:0] banco [PROF];

    logic               end_valido;
    logic               escrita;
    logic               bypass1;
    logic               bypass2;
    logic [LARGURA-1:0] leitura1;
    logic [LARGURA-1:0] leitura2;

    // A write address is usable only if it maps to a real, non-hardwired reg.
    assign end_valido = ({1'b0, entrada3} < (END_W+1)'(NUM_REGS)) &&
                        !((R0_ZERO != 0) && (entrada3 == '0));
    assign escrita    = sinal && !ocupado && end_valido;

    // Bypass forwards the data being written this edge to a matching reader.
    assign bypass1  = escrita && (entrada3 == entrada1);
    assign bypass2  = escrita && (entrada3 == entrada2);
    assign leitura1 = bypass1 ? dado : banco[entrada1];
    assign leitura2 = bypass2 ? dado : banco[entrada2];

    // One storage element per real register; everything else is tied to 0.
    generate
        for (genvar gi = 0; gi < PROF; gi++) begin : g_banco
            if ((gi < NUM_REGS) && !((R0_ZERO != 0) && (gi == 0))) begin : g_reg
                logic [LARGURA-1:0] valor;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        valor <= '0;
                    end else if ((estado == LIMPANDO) &&
                                 (contador == (END_W+1)'(gi))) begin
                        valor <= '0;
                    end else if (escrita && (entrada3 == END_W'(gi))) begin
                        valor <= dado;
                    end
                end

                assign banco[gi] = valor;
            end else begin : g_zero
                assign banco[gi] = '0;
            end
        end
    endgenerate

    // Clear sweep sequencer. ocupado is registered alongside the state so it
    // is high for exactly NUM_REGS cycles, starting after the limpar edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            contador <= '0;
            ocupado  <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (limpar) begin
                        estado   <= LIMPANDO;
                        contador <= '0;
                        ocupado  <= 1'b1;
                    end
                end
                LIMPANDO: begin
                    if (contador == ULTIMO) begin
                        estado   <= OCIOSO;
                        contador <= '0;
                        ocupado  <= 1'b0;
                    end else begin
                        contador <= contador + (END_W+1)'(1);
                    end
                end
                default: begin
                    estado   <= OCIOSO;
                    contador <= '0;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read ports: data holds when not enabled, valid pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            saida1  <= '0;
            saida2  <= '0;
            valido1 <= 1'b0;
            valido2 <= 1'b0;
        end else begin
            if (le1 && !ocupado) begin
                saida1  <= leitura1;
                valido1 <= 1'b1;
            end else begin
                valido1 <= 1'b0;
            end
            if (le2 && !ocupado) begin
                saida2  <= leitura2;
                valido2 <= 1'b1;
            end else begin
                valido2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_banco_registradores_param.sv
// ---------------------------------------------------------------------------
// tb_banco_registradores_param
//
// Drives three instances in parallel from shared stimulus:
//   inst0: 16 regs, R0 writable   inst1: 16 regs, R0 hardwired zero
//   inst2: 12 regs (out-of-range addresses 12..15)
// A behavioural model (plain arrays plus a countdown for the sweep) tracks
// each instance's expected outputs.
// ---------------------------------------------------------------------------
module tb_banco_registradores_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sinal = 1'b0;
    logic        le1 = 1'b0;
    logic        le2 = 1'b0;
    logic        limpar = 1'b0;
    logic [3:0]  entrada1 = '0;
    logic [3:0]  entrada2 = '0;
    logic [3:0]  entrada3 = '0;
    logic [15:0] dado = '0;

    logic [15:0] s1 [3];
    logic [15:0] s2 [3];
    logic        v1 [3];
    logic        v2 [3];
    logic        oc [3];

    int checks = 0;
    int passed = 0;

    int nr  [3] = '{16, 16, 12};
    int r0z [3] = '{0, 1, 0};

    // Reference model state
    logic [15:0] mreg [3][16];
    logic [15:0] ms1 [3];
    logic [15:0] ms2 [3];
    logic        mv1 [3];
    logic        mv2 [3];
    int          busy_left [3];
    int          sweep_idx [3];

    always #5 clk = ~clk;

    banco_registradores_param #(.LARGURA(16), .NUM_REGS(16), .END_W(4), .R0_ZERO(0)) u0 (
        .clk(clk), .reset_n(reset_n), .sinal(sinal),
        .entrada1(entrada1), .entrada2(entrada2), .entrada3(entrada3),
        .dado(dado), .le1(le1), .le2(le2), .limpar(limpar),
        .saida1(s1[0]), .saida2(s2[0]), .valido1(v1[0]), .valido2(v2[0]), .ocupado(oc[0])
    );

    banco_registradores_param #(.LARGURA(16), .NUM_REGS(16), .END_W(4), .R0_ZERO(1)) u1 (
        .clk(clk), .reset_n(reset_n), .sinal(sinal),
        .entrada1(entrada1), .entrada2(entrada2), .entrada3(entrada3),
        .dado(dado), .le1(le1), .le2(le2), .limpar(limpar),
        .saida1(s1[1]), .saida2(s2[1]), .valido1(v1[1]), .valido2(v2[1]), .ocupado(oc[1])
    );

    banco_registradores_param #(.LARGURA(16), .NUM_REGS(12), .END_W(4), .R0_ZERO(0)) u2 (
        .clk(clk), .reset_n(reset_n), .sinal(sinal),
        .entrada1(entrada1), .entrada2(entrada2), .entrada3(entrada3),
        .dado(dado), .le1(le1), .le2(le2), .limpar(limpar),
        .saida1(s1[2]), .saida2(s2[2]), .valido1(v1[2]), .valido2(v2[2]), .ocupado(oc[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_read(int k, int a);
        if (a >= nr[k] || (r0z[k] != 0 && a == 0)) return 16'h0000;
        return mreg[k][a];
    endfunction

    function automatic bit model_writable(int k, int a);
        return (a < nr[k]) && !(r0z[k] != 0 && a == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 16; a++) mreg[k][a] = '0;
            ms1[k] = '0; ms2[k] = '0; mv1[k] = 1'b0; mv2[k] = 1'b0;
            busy_left[k] = 0; sweep_idx[k] = 0;
        end
    endtask

    // Apply one rising edge's worth of behaviour using the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit busy;
            bit wok;
            busy = busy_left[k] > 0;
            wok  = sinal && !busy && model_writable(k, int'(entrada3));
            if (le1 && !busy) begin
                ms1[k] = (wok && entrada3 == entrada1) ? dado : model_read(k, int'(entrada1));
                mv1[k] = 1'b1;
            end else begin
                mv1[k] = 1'b0;
            end
            if (le2 && !busy) begin
                ms2[k] = (wok && entrada3 == entrada2) ? dado : model_read(k, int'(entrada2));
                mv2[k] = 1'b1;
            end else begin
                mv2[k] = 1'b0;
            end
            if (wok) mreg[k][entrada3] = dado;
            if (busy) begin
                mreg[k][sweep_idx[k]] = '0;
                sweep_idx[k]++;
                busy_left[k]--;
            end else if (limpar) begin
                busy_left[k] = nr[k];
                sweep_idx[k] = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sinal = 1'b0; le1 = 1'b0; le2 = 1'b0; limpar = 1'b0;
        entrada1 = '0; entrada2 = '0; entrada3 = '0; dado = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sinal = 1'b1; entrada3 = 4'd3; dado = 16'h3333; tick();
        entrada3 = 4'd15; dado = 16'hF0F0; tick();
        entrada3 = 4'd3; le1 = 1'b1; entrada1 = 4'd3; sinal = 1'b0; tick();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({s1[k], s2[k], v1[k], v2[k], oc[k]} !== 35'h0)
                $display("FAIL reset_outputs inst%0d: got %h expected 0", k,
                         {s1[k], s2[k], v1[k], v2[k], oc[k]});
            else passed++;
        end
        #1;
        reset_n = 1'b1;
        le1 = 1'b1; le2 = 1'b1; entrada1 = 4'd3; entrada2 = 4'd15;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({s1[k], s2[k], v1[k], v2[k]} !== {16'h0, 16'h0, 1'b1, 1'b1})
                $display("FAIL reset_read inst%0d: got s1=%h s2=%h v1=%b v2=%b expected 0/0/1/1",
                         k, s1[k], s2[k], v1[k], v2[k]);
            else passed++;
        end
        idle_inputs();
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        sinal = 1'b1; entrada3 = 4'd5; dado = 16'hA5A5; tick();
        sinal = 1'b0; le1 = 1'b1; entrada1 = 4'd5; tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (s1[k] !== 16'hA5A5 || v1[k] !== 1'b1)
                $display("FAIL write_read inst%0d: got %h v=%b expected a5a5 v=1", k, s1[k], v1[k]);
            else passed++;
        end
        le1 = 1'b0; tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (s1[k] !== 16'hA5A5 || v1[k] !== 1'b0)
                $display("FAIL read_hold inst%0d: got %h v=%b expected a5a5 v=0", k, s1[k], v1[k]);
            else passed++;
        end
        idle_inputs();
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        sinal = 1'b1; entrada3 = 4'd7; dado = 16'h1111; tick();
        dado = 16'h2222; le1 = 1'b1; le2 = 1'b1; entrada1 = 4'd7; entrada2 = 4'd7; tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (s1[k] !== 16'h2222 || s2[k] !== 16'h2222)
                $display("FAIL bypass inst%0d: got s1=%h s2=%h expected 2222/2222", k, s1[k], s2[k]);
            else passed++;
        end
        sinal = 1'b0; le2 = 1'b0; tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (s1[k] !== 16'h2222 || v2[k] !== 1'b0)
                $display("FAIL bypass_stored inst%0d: got s1=%h v2=%b expected 2222 v2=0", k, s1[k], v2[k]);
            else passed++;
        end
        idle_inputs();
        $display("test_bypass done");
    endtask

    task automatic test_r0_zero();
        logic [15:0] exp;
        sinal = 1'b1; entrada3 = 4'd0; dado = 16'hFFFF; le1 = 1'b1; entrada1 = 4'd0; tick();
        for (int k = 0; k < 3; k++) begin
            exp = (r0z[k] != 0) ? 16'h0000 : 16'hFFFF;
            checks++;
            if (s1[k] !== exp)
                $display("FAIL r0_bypass inst%0d: got %h expected %h", k, s1[k], exp);
            else passed++;
        end
        sinal = 1'b0; tick();
        for (int k = 0; k < 3; k++) begin
            exp = (r0z[k] != 0) ? 16'h0000 : 16'hFFFF;
            checks++;
            if (s1[k] !== exp || v1[k] !== 1'b1)
                $display("FAIL r0_read inst%0d: got %h v=%b expected %h v=1", k, s1[k], v1[k], exp);
            else passed++;
        end
        idle_inputs();
        $display("test_r0_zero done");
    endtask

    task automatic test_sweep();
        int cnt [3];
        for (int a = 0; a < 16; a++) begin
            sinal = 1'b1; entrada3 = 4'(a); dado = 16'h1000 + 16'(a) + 16'h1; tick();
        end
        limpar = 1'b1; sinal = 1'b1; entrada3 = 4'd2; dado = 16'hBEEF;
        le1 = 1'b1; entrada1 = 4'd2; le2 = 1'b1; entrada2 = 4'd4;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (oc[k] !== 1'b1 || s1[k] !== 16'hBEEF || v1[k] !== 1'b1 || s2[k] !== 16'h1005)
                $display("FAIL sweep_start inst%0d: got oc=%b s1=%h v1=%b s2=%h expected 1/beef/1/1005",
                         k, oc[k], s1[k], v1[k], s2[k]);
            else passed++;
            cnt[k] = 1;
        end
        limpar = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) begin
                sinal = 1'b1; entrada3 = 4'd9; dado = 16'h1234;
                le1 = 1'b1; le2 = 1'b1; entrada1 = 4'd9; entrada2 = 4'd2;
            end else begin
                idle_inputs();
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                if (i < 10) begin
                    checks++;
                    if (v1[k] !== 1'b0 || v2[k] !== 1'b0)
                        $display("FAIL sweep_read_ignored inst%0d cyc%0d: got v1=%b v2=%b expected 0/0",
                                 k, i, v1[k], v2[k]);
                    else passed++;
                end
                if (oc[k] === 1'b1) cnt[k]++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt[k] !== nr[k])
                $display("FAIL sweep_length inst%0d: got %0d cycles expected %0d", k, cnt[k], nr[k]);
            else passed++;
        end
        for (int a = 0; a < 16; a++) begin
            le1 = 1'b1; le2 = 1'b1; entrada1 = 4'(a); entrada2 = 4'(15 - a);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({s1[k], s2[k], v1[k], v2[k]} !== {16'h0, 16'h0, 1'b1, 1'b1})
                    $display("FAIL sweep_cleared inst%0d addr%0d: got s1=%h s2=%h v1=%b v2=%b expected 0/0/1/1",
                             k, a, s1[k], s2[k], v1[k], v2[k]);
                else passed++;
            end
        end
        idle_inputs();
        $display("test_sweep done");
    endtask

    task automatic test_reset_mid_sweep();
        logic [15:0] exp;
        limpar = 1'b1; tick();
        limpar = 1'b0;
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (oc[k] !== 1'b1)
                $display("FAIL midsweep_busy inst%0d: got oc=%b expected 1", k, oc[k]);
            else passed++;
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (oc[k] !== 1'b0 || s1[k] !== 16'h0 || v1[k] !== 1'b0)
                $display("FAIL midsweep_reset inst%0d: got oc=%b s1=%h v1=%b expected 0/0/0",
                         k, oc[k], s1[k], v1[k]);
            else passed++;
        end
        #1;
        reset_n = 1'b1;
        sinal = 1'b1; entrada3 = 4'd13; dado = 16'h7777; tick();
        sinal = 1'b0; le1 = 1'b1; entrada1 = 4'd13; tick();
        for (int k = 0; k < 3; k++) begin
            exp = (nr[k] <= 13) ? 16'h0000 : 16'h7777;
            checks++;
            if (s1[k] !== exp || v1[k] !== 1'b1)
                $display("FAIL out_of_range inst%0d: got %h v=%b expected %h v=1", k, s1[k], v1[k], exp);
            else passed++;
        end
        idle_inputs();
        $display("test_reset_mid_sweep done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sinal    = 1'($urandom_range(0, 1));
            le1      = 1'($urandom_range(0, 1));
            le2      = 1'($urandom_range(0, 1));
            limpar   = ($urandom_range(0, 39) == 0);
            entrada1 = 4'($urandom_range(0, 15));
            entrada2 = ($urandom_range(0, 3) == 0) ? entrada1 : 4'($urandom_range(0, 15));
            entrada3 = ($urandom_range(0, 3) == 0) ? entrada1 : 4'($urandom_range(0, 15));
            dado     = 16'($urandom);
            tick();
            $display("rnd %0d: we=%b wa=%0d d=%h r1=%0d/%b r2=%0d/%b clr=%b", c, sinal, entrada3,
                     dado, entrada1, le1, entrada2, le2, limpar);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({s1[k], s2[k], v1[k], v2[k], oc[k]} !==
                    {ms1[k], ms2[k], mv1[k], mv2[k], (busy_left[k] > 0)})
                    $display("FAIL random cyc%0d inst%0d: got %h_%h_%b%b%b expected %h_%h_%b%b%b",
                             c, k, s1[k], s2[k], v1[k], v2[k], oc[k],
                             ms1[k], ms2[k], mv1[k], mv2[k], (busy_left[k] > 0));
                else passed++;
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_r0_zero();
        test_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
